// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the key schedule and round datapath.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef block_t       rkey_array_t [0:10];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational (zero latency, no handshake).
// Computed as GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Addition chain to x^254; zero maps to zero without special-casing.
  always_comb begin
    x2   = gf_mul(in_i, in_i);
    x3   = gf_mul(x2, in_i);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, in_i);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, in_i);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, in_i);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, in_i);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, in_i);
    inv  = gf_mul(x127, x127);
  end

  assign out_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock, 11 edges from accept to keys_valid.
// key_ready is low while expanding; a key offered then is ignored, not queued.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             zeroize,
  output logic             busy,
  output logic             keys_valid,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out
);

  if (NUM_ROUNDS != AES_NR || KEY_W != 128) begin : g_param_check
    $error("aes_key_expand supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  rkey_array_t rk_q, rk_d;

  block_t      prev_key, next_key;
  word_t       rot_w, sub_w, temp_w;
  word_t       w0n, w1n, w2n, w3n;
  logic [7:0]  rcon;

  always_comb begin
    prev_key = '0;
    rcon     = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (cnt_q == 4'(i)) begin
        prev_key = rk_q[i-1];
        rcon     = RCON[i];
      end
    end
  end

  assign rot_w = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_w[8*b +: 8]),
      .out_o (sub_w[8*b +: 8])
    );
  end

  assign temp_w   = sub_w ^ {rcon, 24'h0};
  assign w0n      = prev_key[127:96] ^ temp_w;
  assign w1n      = prev_key[95:64]  ^ w0n;
  assign w2n      = prev_key[63:32]  ^ w1n;
  assign w3n      = prev_key[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    if (zeroize) begin
      // Wipe wins over any simultaneous accept.
      for (int i = 0; i <= 10; i++) rk_d[i] = '0;
      cnt_d   = 4'd0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, READY: begin
          if (key_valid) begin
            rk_d[0] = key_in;
            cnt_d   = 4'd1;
            state_d = EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= 10; i++) begin
            if (cnt_q == 4'(i)) rk_d[i] = next_key;
          end
          if (cnt_q == 4'd10) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
    end
  end

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == READY);

  always_comb begin
    rk_out = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rk_idx == 4'(i)) rk_out = rk_q[i];
    end
  end

endmodule
